// File: rtl/nand_pkg.sv
// Shared types and default timing for the NAND bus-cycle engine.
package nand_pkg;

    typedef enum logic [1:0] {
        REQ_CMD   = 2'b00,
        REQ_ADDR  = 2'b01,
        REQ_WDATA = 2'b10,
        REQ_RDATA = 2'b11
    } req_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WB,
        ST_RBWAIT,
        ST_DONE
    } state_e;

    localparam int DEF_T_SETUP     = 2;
    localparam int DEF_T_PULSE     = 3;
    localparam int DEF_T_HOLD      = 2;
    localparam int DEF_T_WB        = 4;
    localparam int DEF_TIMEOUT_CYC = 1000000;

    // The interval timer counts down to zero, so an N-cycle interval loads N-1.
    function automatic logic [3:0] tmr_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/nand_cyc_timer.sv
// Loadable 4-bit down-counter; o_done is high while the count sits at zero.
module nand_cyc_timer (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_done
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/nand_cycle_engine.sv
// NAND flash bus-cycle engine: one CMD/ADDR/WDATA/RDATA cycle per request.
// Optional R/B# timeout is built when NAND_RB_TIMEOUT_EN is defined.
module nand_cycle_engine
    import nand_pkg::*;
#(
    parameter int T_SETUP     = DEF_T_SETUP,
    parameter int T_PULSE     = DEF_T_PULSE,
    parameter int T_HOLD      = DEF_T_HOLD,
    parameter int T_WB        = DEF_T_WB,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_type,
    input  logic [7:0] req_data,
    input  logic       req_wait_rb,
    input  logic       wp_req,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       nCE,
    output logic       CLE,
    output logic       ALE,
    output logic       nWE,
    output logic       nRE,
    output logic       nWP,
    output logic [7:0] IO_o,
    output logic       IO_oe,
    input  logic [7:0] IO_i,
    input  logic       RB
);

    state_e    r_state;
    state_e    w_state_next;
    req_type_e r_type;
    logic [7:0] r_data;
    logic       r_wait_rb;
    logic       r_last_pulse;
    logic       w_accept;
    logic       w_active;
    logic       w_tmr_load;
    logic [3:0] w_tmr_val;
    logic       w_tmr_done;

    logic       r_nce, r_cle, r_ale, r_nwe, r_nre, r_nwp, r_io_oe, r_rsp_valid;
    logic [7:0] r_io_o, r_rsp_data;

`ifdef NAND_RB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_to_flag;
    logic            r_rsp_err;
    logic            w_to_hit;
`endif

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_ready && req_valid;
    assign w_active  = (r_state inside {ST_SETUP, ST_PULSE, ST_HOLD});

    nand_cyc_timer u_timer (
        .clk        (PCLK),
        .srst       (PRESET),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = 4'd0;
`ifdef NAND_RB_TIMEOUT_EN
        w_to_hit     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: if (req_valid) begin
                w_state_next = ST_SETUP;
                w_tmr_load   = 1'b1;
                w_tmr_val    = tmr_load(T_SETUP);
            end
            ST_SETUP: if (w_tmr_done) begin
                w_state_next = ST_PULSE;
                w_tmr_load   = 1'b1;
                w_tmr_val    = tmr_load(T_PULSE);
            end
            ST_PULSE: if (w_tmr_done) begin
                w_state_next = ST_HOLD;
                w_tmr_load   = 1'b1;
                w_tmr_val    = tmr_load(T_HOLD);
            end
            ST_HOLD: if (w_tmr_done) begin
                if (r_wait_rb) begin
                    w_state_next = ST_WB;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = tmr_load(T_WB);
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            ST_WB: if (w_tmr_done) w_state_next = ST_RBWAIT;
            ST_RBWAIT: begin
                if (RB) w_state_next = ST_DONE;
`ifdef NAND_RB_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    w_state_next = ST_DONE;
                    w_to_hit     = 1'b1;
                end
`endif
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_type    <= REQ_CMD;
            r_data    <= 8'h00;
            r_wait_rb <= 1'b0;
        end else if (w_accept) begin
            r_type    <= req_type_e'(req_type);
            r_data    <= req_data;
            r_wait_rb <= req_wait_rb;
        end
    end

    // Pins are a registered decode of the current state, so the pin view
    // trails r_state by one cycle; RDATA capture is delayed to match.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_nce        <= 1'b1;
            r_cle        <= 1'b0;
            r_ale        <= 1'b0;
            r_nwe        <= 1'b1;
            r_nre        <= 1'b1;
            r_nwp        <= 1'b0;
            r_io_oe      <= 1'b0;
            r_io_o       <= 8'h00;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_last_pulse <= 1'b0;
        end else begin
            r_nce        <= (r_state == ST_IDLE);
            r_cle        <= w_active && (r_type == REQ_CMD);
            r_ale        <= w_active && (r_type == REQ_ADDR);
            r_nwe        <= !((r_state == ST_PULSE) && (r_type != REQ_RDATA));
            r_nre        <= !((r_state == ST_PULSE) && (r_type == REQ_RDATA));
            r_nwp        <= ~wp_req;
            r_io_oe      <= w_active && (r_type != REQ_RDATA);
            r_io_o       <= (w_active && (r_type != REQ_RDATA)) ? r_data : 8'h00;
            r_rsp_valid  <= (r_state == ST_DONE);
            r_last_pulse <= (r_state == ST_PULSE) && w_tmr_done && (r_type == REQ_RDATA);
            if (r_last_pulse) begin
                r_rsp_data <= IO_i;
            end
        end
    end

`ifdef NAND_RB_TIMEOUT_EN
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == ST_RBWAIT) ? r_to_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_to_flag <= 1'b0;
            end else if (w_to_hit) begin
                r_to_flag <= 1'b1;
            end
            if (w_accept) begin
                r_rsp_err <= 1'b0;
            end else if ((r_state == ST_DONE) && r_to_flag) begin
                r_rsp_err <= 1'b1;
            end
        end
    end
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign nCE       = r_nce;
    assign CLE       = r_cle;
    assign ALE       = r_ale;
    assign nWE       = r_nwe;
    assign nRE       = r_nre;
    assign nWP       = r_nwp;
    assign IO_oe     = r_io_oe;
    assign IO_o      = r_io_o;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
